// File: rtl/njdl_pkg.sv
// rtl/njdl_pkg.sv - shared types and widths for the NinjaKun graphics ROM loader
package njdl_pkg;

   localparam int ROMAD_W = 17;
   localparam int DL_AD_W = 25;
   localparam int CNT_W   = 18;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_t;

   typedef struct packed {
      logic [ROMAD_W-1:0] addr;
      logic [7:0]         data;
   } fifo_entry_t;

endpackage

// File: rtl/nj_rom_loader_if.sv
// rtl/nj_rom_loader_if.sv - HPS download channel bundle (host drives, loader consumes)
interface nj_rom_loader_if;
   import njdl_pkg::*;

   logic               DL_ACT;
   logic               DL_WR;
   logic [DL_AD_W-1:0] DL_AD;
   logic [7:0]         DL_DT;
   logic               DL_WAIT;

   modport master (output DL_ACT, output DL_WR, output DL_AD, output DL_DT, input DL_WAIT);
   modport slave  (input DL_ACT, input DL_WR, input DL_AD, input DL_DT, output DL_WAIT);

endinterface

// File: rtl/njdl_fifo.sv
// rtl/njdl_fifo.sv - small synchronous FIFO of {address, data} write entries
module njdl_fifo
   import njdl_pkg::*;
#(
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                push_i,
   input  fifo_entry_t         push_data_i,
   input  logic                pop_i,
   output fifo_entry_t         pop_data_o,
   output logic                full_o,
   output logic                empty_o,
   output logic [DEPTH_LOG2:0] occ_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] OCC_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

   fifo_entry_t             mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_q;
   logic [DEPTH_LOG2-1:0]   rd_ptr_q;
   logic [DEPTH_LOG2:0]     occ_q;
   logic                    do_push;
   logic                    do_pop;

   assign full_o     = (occ_q == OCC_FULL);
   assign empty_o    = (occ_q == '0);
   assign occ_o      = occ_q;
   assign pop_data_o = mem_q[rd_ptr_q];
   assign do_push    = push_i & ~full_o;
   assign do_pop     = pop_i & ~empty_o;

   // Storage array; contents are don't-care while the pointers say empty
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointers and occupancy; reset flushes everything in flight
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      occ_q <= occ_q + 1'b1;
         else if (do_pop && !do_push) occ_q <= occ_q - 1'b1;
      end
   end

endmodule

// File: rtl/nj_rom_loader.sv
// rtl/nj_rom_loader.sv - turns graphics-region download bytes into paced ROMAD/ROMDT/ROMEN writes
module nj_rom_loader
   import njdl_pkg::*;
#(
   parameter logic [DL_AD_W-1:0] GFX_BASE   = 25'h10000,
   parameter logic [CNT_W-1:0]   GFX_SIZE   = 18'h20000,
   parameter int                 GAP        = 1,
   parameter int                 DEPTH_LOG2 = 2
) (
   input  logic               CL,
   input  logic               RST_N,
   nj_rom_loader_if.slave     dl,
   output logic [ROMAD_W-1:0] ROMAD,
   output logic [7:0]         ROMDT,
   output logic               ROMEN,
   output logic               DONE,
   output logic               ERR,
   output logic [15:0]        SUM
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GAP_W-1:0]      GAP_RELOAD = GAP_W'(GAP - 1);
   localparam logic [DEPTH_LOG2:0]   OCC_HI     = (DEPTH_LOG2 + 1)'(DEPTH - 1);
   localparam logic [DL_AD_W:0]      GFX_END    = {1'b0, GFX_BASE} + {8'd0, GFX_SIZE};

   state_t               state_q, state_d;
   logic [GAP_W-1:0]     gap_q, gap_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [15:0]          sum_q, sum_d;
   logic                 err_q, err_d;
   logic                 done_q, done_d;
   logic                 wait_q, wait_d;
   logic [ROMAD_W-1:0]   romad_q;
   logic [7:0]           romdt_q;
   logic                 romen_q;

   logic                 in_range;
   logic                 push;
   logic                 pop;
   logic [DEPTH_LOG2:0]  occ_nxt;
   fifo_entry_t          push_entry;
   fifo_entry_t          pop_entry;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DEPTH_LOG2:0]  fifo_occ;

   assign in_range        = ({1'b0, dl.DL_AD} >= {1'b0, GFX_BASE}) && ({1'b0, dl.DL_AD} < GFX_END);
   assign push_entry.addr = ROMAD_W'(dl.DL_AD - GFX_BASE);
   assign push_entry.data = dl.DL_DT;

   assign dl.DL_WAIT = wait_q;
   assign ROMAD      = romad_q;
   assign ROMDT      = romdt_q;
   assign ROMEN      = romen_q;
   assign DONE       = done_q;
   assign ERR        = err_q;
   assign SUM        = sum_q;

   njdl_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .clk_i       (CL),
      .rst_ni      (RST_N),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .pop_data_o  (pop_entry),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .occ_o       (fifo_occ)
   );

   // Download phase register
   always_ff @(posedge CL or negedge RST_N) begin
      if (!RST_N) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Phase sequencing: a new download may only start from IDLE or FIN
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_FIN: if (dl.DL_ACT) state_d = ST_LOAD;
         ST_LOAD:         if (!dl.DL_ACT) state_d = ST_DRAIN;
         ST_DRAIN:        if (fifo_empty && gap_q == '0) state_d = ST_FIN;
         default:         state_d = ST_IDLE;
      endcase
   end

   // Push/pop decisions and next values of count, checksum, status and pacing
   always_comb begin
      push   = 1'b0;
      pop    = !fifo_empty && (gap_q == '0);
      cnt_d  = cnt_q;
      sum_d  = sum_q;
      err_d  = err_q;
      done_d = done_q;
      if (pop)              gap_d = GAP_RELOAD;
      else if (gap_q != '0) gap_d = gap_q - 1'b1;
      else                  gap_d = gap_q;

      if (state_q != ST_LOAD && state_d == ST_LOAD) begin
         cnt_d  = '0;
         sum_d  = '0;
         err_d  = 1'b0;
         done_d = 1'b0;
      end

      // Full is judged on the pre-edge occupancy, so a same-cycle pop never frees a slot
      if (state_q == ST_LOAD && dl.DL_WR && in_range) begin
         if (fifo_full) begin
            err_d = 1'b1;
         end else begin
            push  = 1'b1;
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            sum_d = sum_q + {8'd0, dl.DL_DT};
         end
      end

      if (state_q == ST_DRAIN && state_d == ST_FIN) begin
         done_d = 1'b1;
         if (cnt_q != GFX_SIZE) err_d = 1'b1;
      end

      occ_nxt = fifo_occ;
      if (push && !pop)      occ_nxt = fifo_occ + 1'b1;
      else if (pop && !push) occ_nxt = fifo_occ - 1'b1;
      // Raised one entry early so a strobe already launched by the host still fits
      wait_d = (occ_nxt >= OCC_HI) || (state_d == ST_DRAIN);
   end

   // Datapath registers and the paced ROM write port
   always_ff @(posedge CL or negedge RST_N) begin
      if (!RST_N) begin
         gap_q   <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         wait_q  <= 1'b0;
         romad_q <= '0;
         romdt_q <= '0;
         romen_q <= 1'b0;
      end else begin
         gap_q   <= gap_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         err_q   <= err_d;
         done_q  <= done_d;
         wait_q  <= wait_d;
         romen_q <= pop;
         if (pop) begin
            romad_q <= pop_entry.addr;
            romdt_q <= pop_entry.data;
         end
      end
   end

endmodule

// File: tb/tb_nj_rom_loader.sv
// tb/tb_nj_rom_loader.sv - scoreboard bench for nj_rom_loader with GAP=1 and GAP=4 instances
module tb_nj_rom_loader;
   import njdl_pkg::*;

   localparam logic [24:0] BASE = 25'h10000;
   localparam logic [17:0] SIZE = 18'h100;
   localparam int          NG   = 256;

   logic CL = 1'b0;
   always #5 CL = ~CL;

   logic [1:0]  rst_n;
   logic [16:0] romad [2];
   logic [7:0]  romdt [2];
   logic [1:0]  romen, done, err;
   logic [15:0] sum [2];

   nj_rom_loader_if dl0 ();
   nj_rom_loader_if dl1 ();

   nj_rom_loader #(.GFX_BASE(BASE), .GFX_SIZE(SIZE), .GAP(1), .DEPTH_LOG2(2)) u_g1 (
      .CL(CL), .RST_N(rst_n[0]), .dl(dl0.slave), .ROMAD(romad[0]), .ROMDT(romdt[0]),
      .ROMEN(romen[0]), .DONE(done[0]), .ERR(err[0]), .SUM(sum[0]));

   nj_rom_loader #(.GFX_BASE(BASE), .GFX_SIZE(SIZE), .GAP(4), .DEPTH_LOG2(2)) u_g4 (
      .CL(CL), .RST_N(rst_n[1]), .dl(dl1.slave), .ROMAD(romad[1]), .ROMDT(romdt[1]),
      .ROMEN(romen[1]), .DONE(done[1]), .ERR(err[1]), .SUM(sum[1]));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int pulses [2] = '{0, 0};
   logic [24:0] exp0 [$];
   logic [24:0] exp1 [$];
   int ptime0 [$];
   int ptime1 [$];

   always @(posedge CL) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input int d, input logic [16:0] a, input logic [7:0] v);
      if (d == 0) exp0.push_back({a, v});
      else        exp1.push_back({a, v});
   endtask

   task automatic drv(input int d, input logic act, input logic wr, input logic [24:0] ad, input logic [7:0] dt);
      if (d == 0) begin
         dl0.DL_ACT = act; dl0.DL_WR = wr; dl0.DL_AD = ad; dl0.DL_DT = dt;
      end else begin
         dl1.DL_ACT = act; dl1.DL_WR = wr; dl1.DL_AD = ad; dl1.DL_DT = dt;
      end
   endtask

   function automatic logic dlwait(input int d);
      return (d == 0) ? dl0.DL_WAIT : dl1.DL_WAIT;
   endfunction

   task automatic wr_byte(input int d, input logic [24:0] ad, input logic [7:0] dt);
      @(posedge CL); #1;
      drv(d, 1'b1, 1'b1, ad, dt);
   endtask

   task automatic start_dl(input int d);
      @(posedge CL); #1;
      drv(d, 1'b1, 1'b0, 25'd0, 8'd0);
   endtask

   task automatic end_dl(input int d);
      @(posedge CL); #1;
      drv(d, 1'b0, 1'b0, 25'd0, 8'd0);
   endtask

   task automatic wait_done(input int d, input string name);
      int k = 0;
      while (done[d] !== 1'b1 && k < 3000) begin
         @(posedge CL); #1;
         k++;
      end
      check(name, done[d], 1'b1);
   endtask

   // Monitor: every ROMEN pulse must match the oldest outstanding expected write
   always @(negedge CL) begin
      if (romen[0] === 1'b1) begin
         pulses[0]++;
         ptime0.push_back(cyc);
         check("g1_sb_has_entry", exp0.size() != 0, 1'b1);
         if (exp0.size() != 0) check("g1_romen_word", {7'd0, romad[0], romdt[0]}, {7'd0, exp0.pop_front()});
      end
      if (romen[1] === 1'b1) begin
         pulses[1]++;
         if (ptime1.size() != 0) check("g4_min_gap", (cyc - ptime1[$]) >= 4, 1'b1);
         ptime1.push_back(cyc);
         check("g4_sb_has_entry", exp1.size() != 0, 1'b1);
         if (exp1.size() != 0) check("g4_romen_word", {7'd0, romad[1], romdt[1]}, {7'd0, exp1.pop_front()});
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  dt;
      logic [15:0] sref;
      int p0, t0, nwait, i, k, first_wait;

      rst_n = 2'b00;
      drv(0, 1'b0, 1'b0, 25'd0, 8'd0);
      drv(1, 1'b0, 1'b0, 25'd0, 8'd0);
      repeat (3) @(posedge CL);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_dl_wait", dlwait(d), 1'b0);
         check("rst_romad", romad[d], 17'd0);
         check("rst_romdt", romdt[d], 8'd0);
         check("rst_romen", romen[d], 1'b0);
         check("rst_done", done[d], 1'b0);
         check("rst_err", err[d], 1'b0);
         check("rst_sum", sum[d], 16'd0);
      end
      rst_n = 2'b11;

      // Full graphics load, GAP=1, one byte per cycle
      start_dl(0);
      sref = 0; nwait = 0; p0 = pulses[0]; t0 = 0;
      for (int j = 0; j < NG; j++) begin
         dt = 8'(j * 7 + 3);
         wr_byte(0, BASE + 25'(j), dt);
         if (j == 0) t0 = cyc;
         if (dlwait(0)) nwait++;
         push_exp(0, 17'(j), dt);
         sref += {8'd0, dt};
      end
      end_dl(0);
      wait_done(0, "t1_done");
      check("t1_err", err[0], 1'b0);
      check("t1_sum", sum[0], sref);
      check("t1_pulses", pulses[0] - p0, NG);
      check("t1_wait_never", nwait, 0);
      check("t1_latency", ptime0[p0] - t0, 2);
      check("t1_last_romad", romad[0], 17'h0FF);
      check("t1_sb_empty", exp0.size(), 0);

      // Graphics load interleaved with out-of-range bytes on both sides of the window
      start_dl(0);
      sref = 0; p0 = pulses[0];
      for (int j = 0; j < NG; j++) begin
         wr_byte(0, 25'h0FFFF - 25'(j), 8'hEE);
         if (j == 0) begin
            check("t2_done_cleared", done[0], 1'b0);
            check("t2_sum_cleared", sum[0], 16'd0);
         end
         dt = 8'(j) ^ 8'h5A;
         wr_byte(0, BASE + 25'(j), dt);
         push_exp(0, 17'(j), dt);
         sref += {8'd0, dt};
         wr_byte(0, 25'h10100 + 25'(j), 8'hDD);
      end
      end_dl(0);
      wait_done(0, "t2_done");
      check("t2_err", err[0], 1'b0);
      check("t2_sum", sum[0], sref);
      check("t2_pulses", pulses[0] - p0, NG);

      // Short download: 20 of 256 bytes
      start_dl(0);
      sref = 0; p0 = pulses[0];
      for (int j = 0; j < 20; j++) begin
         dt = 8'(j + 1);
         wr_byte(0, BASE + 25'(j), dt);
         push_exp(0, 17'(j), dt);
         sref += {8'd0, dt};
      end
      end_dl(0);
      wait_done(0, "t3_done");
      check("t3_err", err[0], 1'b1);
      check("t3_sum", sum[0], sref);
      check("t3_pulses", pulses[0] - p0, 20);

      // GAP=4: reset mid-load with three entries queued and a pulse on ROMEN
      start_dl(1);
      p0 = pulses[1];
      for (int j = 0; j < 5; j++) begin
         wr_byte(1, BASE + 25'(j), 8'hA0 + 8'(j));
         if (j < 2) push_exp(1, 17'(j), 8'hA0 + 8'(j));
      end
      @(posedge CL); #1;
      drv(1, 1'b1, 1'b0, 25'd0, 8'd0);
      @(posedge CL);
      @(negedge CL); #1;
      check("t4_romen_before_rst", romen[1], 1'b1);
      rst_n[1] = 1'b0;
      drv(1, 1'b0, 1'b0, 25'd0, 8'd0);
      #1;
      check("t4_romen_async_drop", romen[1], 1'b0);
      repeat (2) @(posedge CL);
      #1;
      rst_n[1] = 1'b1;
      repeat (20) @(posedge CL);
      #1;
      check("t4_state_idle", u_g4.state_q, ST_IDLE);
      check("t4_sum_zero", sum[1], 16'd0);
      check("t4_pulses", pulses[1] - p0, 2);
      check("t4_sb_empty", exp1.size(), 0);

      // GAP=4, host honours DL_WAIT while offering a byte every cycle
      start_dl(1);
      sref = 0; p0 = pulses[1]; i = 0; k = 0; first_wait = -1;
      while (i < NG && k < 20000) begin
         @(posedge CL); #1;
         k++;
         if (dlwait(1)) begin
            drv(1, 1'b1, 1'b0, 25'd0, 8'd0);
            if (first_wait < 0) first_wait = i;
         end else begin
            dt = 8'(255 - i);
            drv(1, 1'b1, 1'b1, BASE + 25'(i), dt);
            push_exp(1, 17'(i), dt);
            sref += {8'd0, dt};
            i++;
         end
      end
      check("t5_all_sent", i, NG);
      end_dl(1);
      wait_done(1, "t5_done");
      check("t5_err", err[1], 1'b0);
      check("t5_sum_clean", sum[1], sref);
      check("t5_pulses", pulses[1] - p0, NG);
      check("t5_first_wait_occ3", first_wait, 4);
      if (pulses[1] - p0 == NG) check("t5_exact_spacing", ptime1[$] - ptime1[p0], 4 * (NG - 1));

      // GAP=4, host ignores DL_WAIT and bursts 10 bytes: bytes 5,7,8,9 are dropped
      start_dl(1);
      sref = 0; p0 = pulses[1];
      for (int j = 0; j <= 10; j++) begin
         @(posedge CL); #1;
         if (j > 0) check("t6_err_after_byte", err[1], (j - 1) >= 5);
         if (j < 10) begin
            dt = 8'h10 + 8'(j);
            drv(1, 1'b1, 1'b1, BASE + 25'(j), dt);
            if (!(j == 5 || j == 7 || j == 8 || j == 9)) begin
               push_exp(1, 17'(j), dt);
               sref += {8'd0, dt};
            end
         end else begin
            drv(1, 1'b1, 1'b0, 25'd0, 8'd0);
         end
      end
      end_dl(1);
      wait_done(1, "t6_done");
      check("t6_err", err[1], 1'b1);
      check("t6_sum", sum[1], sref);
      check("t6_pulses", pulses[1] - p0, 6);
      check("t6_sb_empty", exp1.size(), 0);

      repeat (4) @(posedge CL);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/nj_rom_loader.md
# nj_rom_loader

Download-side writer for the graphics ROM port of the NinjaKun core. It takes the byte stream delivered by the HPS download channel and turns the graphics-region bytes into paced single-byte writes on the 17-bit ROMAD/ROMDT/ROMEN bus that the graphics ROM blocks decode. A small FIFO decouples host bursts from the output pacing. The block also reports completion, a byte-count/overrun error and a running checksum.

## Interface
Parameters:
- GFX_BASE, 25'h10000: download address of graphics byte 0.
- GFX_SIZE, 18'h20000: expected graphics bytes (128 KiB, fills 17-bit ROMAD).
- GAP, 1: minimum cycles between ROMEN pulses; must be ≥1.
- DEPTH_LOG2, 2: FIFO depth is 2^DEPTH_LOG2 entries.

Ports:
- CL  in  1  clock; all logic on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- DL_ACT  in  1  download in progress.
- DL_WR  in  1  byte strobe, one cycle per byte.
- DL_AD  in  25  byte address in download image.
- DL_DT  in  8  byte data.
- DL_WAIT  out  1  host must hold off DL_WR.
- ROMAD  out  17  write address = DL_AD − GFX_BASE (low 17 bits).
- ROMDT  out  8  write data.
- ROMEN  out  1  one-cycle write strobe.
- DONE  out  1  last download finished and drained.
- ERR  out  1  sticky: overrun or count ≠ GFX_SIZE.
- SUM  out  16  modular sum of accepted bytes.

## Operation
- States: IDLE, LOAD, DRAIN, FIN.
- IDLE/FIN: DL_ACT=1 → LOAD. On entry to LOAD, clear the count, SUM, DONE and ERR; the FIFO is already empty.
- LOAD: in-range test is GFX_BASE ≤ DL_AD < GFX_BASE+GFX_SIZE.
  - DL_WR & in-range & FIFO not full: push {ROMAD, DL_DT}, count+1 (18-bit, saturating), SUM += DL_DT (mod 2^16).
  - DL_WR & out-of-range: discard silently; no count change, no ERR.
  - DL_WR & in-range & FIFO full: drop the byte and set ERR.
  - DL_ACT=0 → DRAIN.
- DRAIN: DL_WR ignored, DL_WAIT=1. When the FIFO is empty and the gap counter is 0 → FIN, DONE=1, and ERR |= (count ≠ GFX_SIZE).
- DL_WR is ignored in IDLE/FIN. DL_ACT rising in DRAIN is not acted on until FIN is reached; the host keeps DL_ACT low for ≥1 cycle between downloads.
- Pop rule: the FIFO is non-empty and the gap counter is 0. The pop registers ROMAD/ROMDT, pulses ROMEN for one cycle and loads the gap counter with GAP−1. The gap counter decrements to 0 otherwise.
- Full is evaluated before the same-cycle pop, so no push is accepted on full. A push and a pop in the same cycle on a non-full, non-empty FIFO leave the occupancy unchanged.
- DL_WAIT = (occupancy ≥ 2^DEPTH_LOG2 − 1) | (state == DRAIN).
- Write order on ROMAD equals acceptance order.

## Timing
- Reset values: state IDLE, FIFO empty, gap 0, and all outputs 0 (DL_WAIT, ROMAD, ROMDT, ROMEN, DONE, ERR, SUM).
- Latency: a byte accepted at edge N gives ROMEN high in cycle N+1 at the earliest, when the FIFO was empty and the gap counter was 0.
- With GAP=1 and the FIFO empty, sustained throughput is 1 byte/cycle and DL_WAIT never asserts.
- DL_WAIT is registered. It reflects occupancy after the current edge, leaving one slot of margin for a strobe already in flight.
- DONE rises one cycle after the last ROMEN of the download, or after the DRAIN gap expires.
- Reset asserted mid-operation: ROMEN drops immediately (asynchronous), the FIFO is flushed and no further writes occur.

## Structure
- Package njdl_pkg holds:
  - the state enum (IDLE/LOAD/DRAIN/FIN);
  - ROMAD_W=17, DL_AD_W=25 and the FIFO entry type {17-bit address, 8-bit data}.
- One sub-module, njdl_fifo: a synchronous FIFO, parameterised by DEPTH_LOG2, with push/pop/full/empty/occupancy outputs and asynchronous active-low reset.

## Test plan
- Full load of 131072 bytes at 0x10000–0x2FFFF, GAP=1, one DL_WR per cycle → 131072 ROMEN pulses, ROMAD 0x00000..0x1FFFF in order, DONE=1, ERR=0, SUM = reference sum mod 2^16.
- Bytes at 0x00000–0x0FFFF and 0x30000–0x3FFFF interleaved with a full graphics load → no extra ROMEN, DONE=1, ERR=0.
- GAP=4, host writes every cycle while honouring DL_WAIT → ROMEN exactly 4 cycles apart, DL_WAIT high at occupancy 3, all bytes written, ERR=0.
- Short download of 1000 graphics bytes then DL_ACT=0 → 1000 ROMEN pulses, then DONE=1, ERR=1.
- GAP=4, host ignores DL_WAIT and bursts 10 bytes → ERR=1 at the first drop, dropped bytes never appear on ROMEN.
- RST_N low mid-LOAD with 3 FIFO entries → ROMEN=0 the same cycle, no pulses after release, state IDLE; a new DL_ACT starts a clean load with SUM=0.
